// File: rtl/am_class_scorer.sv
// Per-class similarity accumulator, argmax classifier and accuracy tally for the
// associative-memory inference path, driven by the AM query-sequencing FSM strobes.
module am_class_scorer #(
  parameter int NUM_CLASSES     = 26,
  parameter int SEQ_CYCLE_COUNT = 10,
  parameter int SEG_W           = 7,
  parameter int SCORE_W         = 11,
  parameter int CLASS_W         = 5,
  parameter int TALLY_W         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [3:0]                   query_ctr,
  input  logic                         comparing_query_hv_with_class_hv,
  input  logic                         inferring_class,
  input  logic                         tallying_accuracy,
  input  logic [NUM_CLASSES*SEG_W-1:0] seg_sim,
  input  logic [CLASS_W-1:0]           true_label,
  input  logic                         clear_tally,
  output logic [CLASS_W-1:0]           predicted_class,
  output logic [SCORE_W-1:0]           best_score,
  output logic                         pred_valid,
  output logic                         pred_correct,
  output logic [TALLY_W-1:0]           correct_count,
  output logic [TALLY_W-1:0]           total_count
);

  localparam int LEAVES = 1 << $clog2(NUM_CLASSES);
  localparam int NODES  = 2 * LEAVES - 1;
  localparam logic [CLASS_W:0] NUM_CLASSES_W = (CLASS_W + 1)'(NUM_CLASSES);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SEG_W-1:0]   b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {{(SCORE_W + 1 - SEG_W){1'b0}}, b};
    if (sum[SCORE_W]) begin
      sat_add = '1;
    end else begin
      sat_add = sum[SCORE_W-1:0];
    end
  endfunction

  logic [SCORE_W-1:0] score_q [NUM_CLASSES];
  logic [SCORE_W-1:0] score_d [NUM_CLASSES];
  logic [CLASS_W-1:0] predicted_class_q, predicted_class_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic               pred_valid_q, pred_valid_d;
  logic               pred_correct_q, pred_correct_d;
  logic [TALLY_W-1:0] correct_count_q, correct_count_d;
  logic [TALLY_W-1:0] total_count_q, total_count_d;

  logic [SCORE_W-1:0] node_score [NODES];
  logic [CLASS_W-1:0] node_idx   [NODES];
  logic               node_vld   [NODES];

  logic accumulate_s, infer_s, tally_s, label_ok_s;

  // Strobe decode with fixed priority accumulate > infer > tally.
  always_comb begin
    accumulate_s = en & comparing_query_hv_with_class_hv;
    infer_s      = en & inferring_class & ~comparing_query_hv_with_class_hv;
    tally_s      = en & tallying_accuracy & ~inferring_class & ~comparing_query_hv_with_class_hv;
    label_ok_s   = ({1'b0, true_label} < NUM_CLASSES_W) && (predicted_class_q == true_label);
  end

  // Argmax compare tree; the left child always holds lower indices, so ties keep it.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      node_score[n] = '0;
      node_idx[n]   = '0;
      node_vld[n]   = 1'b0;
    end
    for (int i = 0; i < NUM_CLASSES; i++) begin
      node_score[LEAVES-1+i] = score_q[i];
      node_idx[LEAVES-1+i]   = CLASS_W'(i);
      node_vld[LEAVES-1+i]   = 1'b1;
    end
    for (int n = LEAVES - 2; n >= 0; n--) begin
      if (node_vld[2*n+1] && (!node_vld[2*n+2] || node_score[2*n+1] >= node_score[2*n+2])) begin
        node_score[n] = node_score[2*n+1];
        node_idx[n]   = node_idx[2*n+1];
      end else begin
        node_score[n] = node_score[2*n+2];
        node_idx[n]   = node_idx[2*n+2];
      end
      node_vld[n] = node_vld[2*n+1] | node_vld[2*n+2];
    end
  end

  // Next-state for scores, prediction and accuracy counters.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      score_d[c] = score_q[c];
    end
    predicted_class_d = predicted_class_q;
    best_score_d      = best_score_q;
    pred_valid_d      = 1'b0;
    pred_correct_d    = pred_correct_q;
    correct_count_d   = correct_count_q;
    total_count_d     = total_count_q;

    if (accumulate_s) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (query_ctr == 4'd0) begin
          score_d[c] = {{(SCORE_W - SEG_W){1'b0}}, seg_sim[c*SEG_W +: SEG_W]};
        end else begin
          score_d[c] = sat_add(score_q[c], seg_sim[c*SEG_W +: SEG_W]);
        end
      end
    end else if (infer_s) begin
      predicted_class_d = node_idx[0];
      best_score_d      = node_score[0];
      pred_valid_d      = 1'b1;
    end else begin
      pred_valid_d = 1'b0;
    end

    // Clear wins over a coincident tally, which is then lost.
    if (clear_tally) begin
      correct_count_d = '0;
      total_count_d   = '0;
      pred_correct_d  = 1'b0;
    end else if (tally_s) begin
      pred_correct_d = label_ok_s;
      if (total_count_q != {TALLY_W{1'b1}}) begin
        total_count_d = total_count_q + TALLY_W'(1);
        if (label_ok_s) begin
          correct_count_d = correct_count_q + TALLY_W'(1);
        end else begin
          correct_count_d = correct_count_q;
        end
      end else begin
        total_count_d = total_count_q;
      end
    end else begin
      pred_correct_d = pred_correct_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        score_q[c] <= '0;
      end
      predicted_class_q <= '0;
      best_score_q      <= '0;
      pred_valid_q      <= 1'b0;
      pred_correct_q    <= 1'b0;
      correct_count_q   <= '0;
      total_count_q     <= '0;
    end else begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        score_q[c] <= score_d[c];
      end
      predicted_class_q <= predicted_class_d;
      best_score_q      <= best_score_d;
      pred_valid_q      <= pred_valid_d;
      pred_correct_q    <= pred_correct_d;
      correct_count_q   <= correct_count_d;
      total_count_q     <= total_count_d;
    end
  end

  assign predicted_class = predicted_class_q;
  assign best_score      = best_score_q;
  assign pred_valid      = pred_valid_q;
  assign pred_correct    = pred_correct_q;
  assign correct_count   = correct_count_q;
  assign total_count     = total_count_q;

endmodule

// File: tb/tb_am_class_scorer.sv
// Scoreboard bench for am_class_scorer: directed queries push expected predictions and
// tallies; a negedge monitor pops and compares. A narrow second instance covers saturation.
module tb_am_class_scorer;
  localparam int NC = 26;
  localparam int SW = 7;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, en = 1'b1, cmp = 1'b0, inf = 1'b0, tly = 1'b0, clr = 1'b0;
  logic [3:0]       qctr = 4'd0;
  logic [NC*SW-1:0] sims = '0;
  logic [CW-1:0]    label = '0;
  logic [CW-1:0]    predicted_class;
  logic [10:0]      best_score;
  logic             pred_valid, pred_correct;
  logic [15:0]      correct_count, total_count;

  logic             en2 = 1'b0, cmp2 = 1'b0, inf2 = 1'b0, tly2 = 1'b0, clr2 = 1'b0;
  logic [3:0]       qctr2 = 4'd0;
  logic [NC*SW-1:0] sims2 = '0;
  logic [CW-1:0]    label2 = '0;
  logic [CW-1:0]    pc2;
  logic [7:0]       bs2;
  logic             pv2, pcor2;
  logic [3:0]       cc2, tc2;

  am_class_scorer dut (
    .clk(clk), .rst(rst), .en(en), .query_ctr(qctr),
    .comparing_query_hv_with_class_hv(cmp), .inferring_class(inf),
    .tallying_accuracy(tly), .seg_sim(sims), .true_label(label), .clear_tally(clr),
    .predicted_class(predicted_class), .best_score(best_score), .pred_valid(pred_valid),
    .pred_correct(pred_correct), .correct_count(correct_count), .total_count(total_count)
  );

  am_class_scorer #(.SCORE_W(8), .TALLY_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en2), .query_ctr(qctr2),
    .comparing_query_hv_with_class_hv(cmp2), .inferring_class(inf2),
    .tallying_accuracy(tly2), .seg_sim(sims2), .true_label(label2), .clear_tally(clr2),
    .predicted_class(pc2), .best_score(bs2), .pred_valid(pv2),
    .pred_correct(pcor2), .correct_count(cc2), .total_count(tc2)
  );

  typedef struct packed { logic [4:0] cls; logic [10:0] score; } pred_t;
  typedef struct packed { logic [15:0] cor; logic [15:0] tot; logic pc; } tally_t;

  pred_t  pred_q[$];
  tally_t tally_q[$];
  int     errors = 0;
  int     checks = 0;
  logic [15:0] mc = 16'd0, mt = 16'd0;
  logic        mp = 1'b0;
  logic        tally_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_sims(input int c1, input int v1, input int c2, input int v2, input int oth);
    for (int c = 0; c < NC; c++) begin
      if (c == c1) sims[c*SW +: SW] = SW'(v1);
      else if (c == c2) sims[c*SW +: SW] = SW'(v2);
      else sims[c*SW +: SW] = SW'(oth);
    end
  endtask

  task automatic query(input int c1, input int v1, input int c2, input int v2, input int oth,
                       input int gap, input int lbl, input logic clear,
                       input int exp_cls, input int exp_score);
    pred_t  pe;
    tally_t te;
    for (int q = 0; q < 10; q++) begin
      cmp  = 1'b1;
      qctr = 4'(q);
      set_sims(c1, v1, c2, v2, oth);
      if (q == gap) begin
        en = 1'b0;
        set_sims(0, 127, -1, 0, 127);
        repeat (3) tick;
        en = 1'b1;
        set_sims(c1, v1, c2, v2, oth);
      end
      tick;
    end
    cmp = 1'b0;
    inf = 1'b1;
    pe.cls   = 5'(exp_cls);
    pe.score = 11'(exp_score);
    pred_q.push_back(pe);
    tick;
    inf = 1'b0;
    if (clear) begin
      mc = 16'd0; mt = 16'd0; mp = 1'b0;
    end else if (mt != 16'hFFFF) begin
      mt = mt + 16'd1;
      mp = (lbl == exp_cls);
      if (mp) mc = mc + 16'd1;
    end
    te.cor = mc; te.tot = mt; te.pc = mp;
    tally_q.push_back(te);
    tly   = 1'b1;
    clr   = clear;
    label = CW'(lbl);
    tick;
    tly = 1'b0;
    clr = 1'b0;
  endtask

  // Marks cycles whose counter update the monitor must check at the next negedge.
  always @(posedge clk) tally_seen <= (en & tly) | clr;

  // Monitor: pops the scoreboard whenever the DUT presents a prediction or tally result.
  always @(negedge clk) begin
    pred_t  p;
    tally_t t;
    if (pred_valid) begin
      if (pred_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pred_valid: pulse with no expected prediction (class %0d)", predicted_class);
      end else begin
        p = pred_q.pop_front();
        check("predicted_class", predicted_class, p.cls);
        check("best_score", best_score, p.score);
      end
    end
    if (tally_seen) begin
      if (tally_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tally: counter update with no expected entry (total %0d)", total_count);
      end else begin
        t = tally_q.pop_front();
        check("correct_count", correct_count, t.cor);
        check("total_count", total_count, t.tot);
        check("pred_correct", pred_correct, t.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    pred_t pe;
    repeat (2) tick;
    rst = 1'b0;
    check("rst_predicted_class", predicted_class, 0);
    check("rst_best_score", best_score, 0);
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_correct", pred_correct, 0);
    check("rst_correct_count", correct_count, 0);
    check("rst_total_count", total_count, 0);
    inf = 1'b1;
    pe.cls = 5'd0; pe.score = 11'd0;
    pred_q.push_back(pe);
    tick;
    inf = 1'b0;
    tick;

    query(7, 5, -1, 0, 3, -1, 7, 1'b0, 7, 50);
    query(3, 4, 12, 4, 2, -1, 12, 1'b0, 3, 40);
    query(2, 9, -1, 0, 1, -1, 2, 1'b0, 2, 90);
    query(20, 6, 2, 0, 2, -1, 20, 1'b0, 20, 60);
    query(15, 7, -1, 0, 3, 5, 15, 1'b0, 15, 70);
    query(1, 3, -1, 0, 0, -1, 1, 1'b1, 1, 30);
    query(25, 12, -1, 0, 11, -1, 25, 1'b0, 25, 120);
    query(0, 2, -1, 0, 1, -1, 31, 1'b0, 0, 20);
    repeat (3) tick;

    en2 = 1'b1;
    sims2 = '1;
    for (int q = 0; q < 10; q++) begin
      cmp2 = 1'b1;
      qctr2 = 4'(q);
      tick;
    end
    cmp2 = 1'b0;
    inf2 = 1'b1;
    tick;
    inf2 = 1'b0;
    check("sat_predicted_class", pc2, 0);
    check("sat_best_score", bs2, 255);
    check("sat_pred_valid", pv2, 1);
    tly2 = 1'b1;
    label2 = 5'd0;
    repeat (15) tick;
    tly2 = 1'b0;
    tick;
    check("sat_total_at_max", tc2, 15);
    check("sat_correct_at_max", cc2, 15);
    tly2 = 1'b1;
    repeat (2) tick;
    tly2 = 1'b0;
    tick;
    check("sat_total_hold", tc2, 15);
    check("sat_correct_hold", cc2, 15);
    check("sat_pred_correct", pcor2, 1);

    check("pred_queue_drained", pred_q.size(), 0);
    check("tally_queue_drained", tally_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
